// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write arbiter in front of the register file.
// Picks one pending requester, drives a one-cycle one-hot rf_en plus rf_d_in,
// and pulses ack to the winner. Every write is followed by one IDLE cycle.
// Optional build macro REG0_ZERO_EN: register 0 is hard-wired to zero, so a
// write to address 0 is still acked but never raises rf_en[0].
module regfile_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int NUM_REG = 8,
   parameter int ADDR_W  = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REG-1:0]        rf_en,
   output logic [DATA_W-1:0]         rf_d_in,
   output logic                      busy,
   output logic [2:0]                last_grant
);

   typedef enum logic {IDLE, WRITE} state_t;
   state_t state;

   logic               win_vld;
   logic [2:0]         win_idx;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic [NUM_REG-1:0] en_nxt;
   logic [NUM_REQ-1:0] ack_nxt;

   // Round-robin search: first set req starting just after last_grant.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_addr = '0;
      win_data = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
               win_vld  = 1'b1;
               win_idx  = 3'(i);
               win_addr = addr[i*ADDR_W +: ADDR_W];
               win_data = wdata[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Decode winner address to a one-hot enable and winner index to an ack vector.
   // Out-of-range addresses match no register, so the enable stays all zero.
   always_comb begin
      en_nxt  = '0;
      ack_nxt = '0;
      for (int r = 0; r < NUM_REG; r++)
         en_nxt[r] = (win_addr == ADDR_W'(r));
`ifdef REG0_ZERO_EN
      en_nxt[0] = 1'b0;
`else
      en_nxt[0] = (win_addr == '0);
`endif
      for (int i = 0; i < NUM_REQ; i++)
         ack_nxt[i] = (win_idx == 3'(i));
   end

   // Two-state sequencer with registered outputs; reset overrides any grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack        <= '0;
         rf_en      <= '0;
         rf_d_in    <= '0;
         busy       <= 1'b0;
         last_grant <= 3'(NUM_REQ-1);
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  rf_en      <= en_nxt;
                  rf_d_in    <= win_data;
                  ack        <= ack_nxt;
                  last_grant <= win_idx;
                  busy       <= 1'b1;
                  state      <= WRITE;
               end else begin
                  ack   <= '0;
                  rf_en <= '0;
                  busy  <= 1'b0;
               end
            end
            WRITE: begin
               // Mandatory turnaround so a held req is not granted twice back to back.
               ack   <= '0;
               rf_en <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed steps followed by a randomized run,
// every cycle compared against a transaction-level reference model.
module tb_regfile_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    ack;
   logic [NR-1:0]   rf_en;
   logic [DW-1:0]   rf_d_in;
   logic            busy;
   logic [2:0]      last_grant;

   regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .NUM_REG(NR), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
      .ack(ack), .rf_en(rf_en), .rf_d_in(rf_d_in), .busy(busy), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: what the outputs should be after the next edge.
   logic [N-1:0]  m_ack;
   logic [NR-1:0] m_en;
   logic [DW-1:0] m_d;
   logic          m_busy;
   int            m_lg;

`ifdef REG0_ZERO_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_edge();
      int w;
      int a;
      if (reset) begin
         m_ack = '0; m_en = '0; m_d = '0; m_busy = 1'b0; m_lg = N-1;
      end else if (m_busy) begin
         m_ack = '0; m_en = '0; m_busy = 1'b0;
      end else if (req != '0) begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_lg + k) % N]) w = (m_lg + k) % N;
         a = int'(addr[w*AW +: AW]);
         m_ack = '0;
         m_ack[w] = 1'b1;
         m_en = '0;
         if (a < NR && !(ZERO_REG && a == 0)) m_en[a] = 1'b1;
         m_d = wdata[w*DW +: DW];
         m_lg = w;
         m_busy = 1'b1;
      end else begin
         m_ack = '0; m_en = '0;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".ack"},        64'(ack),        64'(m_ack));
      check({tag, ".rf_en"},      64'(rf_en),      64'(m_en));
      check({tag, ".rf_d_in"},    64'(rf_d_in),    64'(m_d));
      check({tag, ".busy"},       64'(busy),       64'(m_busy));
      check({tag, ".last_grant"}, 64'(last_grant), 64'(m_lg));
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
      req[i] = 1'b1;
   endtask

   initial begin
      logic [31:0] r;
      reset = 1'b1; req = '0; addr = '0; wdata = '0;
      m_ack = '0; m_en = '0; m_d = '0; m_busy = 1'b0; m_lg = N-1;

      // 1. reset with all requests pending: nothing granted
      req = 4'b1111;
      step("rst0");
      step("rst1");
      check("rst.ack", 64'(ack), 64'h0);
      check("rst.rf_en", 64'(rf_en), 64'h0);
      check("rst.busy", 64'(busy), 64'h0);
      check("rst.last_grant", 64'(last_grant), 64'd3);
      req = '0;
      reset = 1'b0;
      step("idle");

      // 2. single write from requester 2
      set_req(2, 3'd5, 32'h01010101);
      step("single");
      check("single.rf_en", 64'(rf_en), 64'h20);
      check("single.rf_d_in", 64'(rf_d_in), 64'h01010101);
      check("single.ack", 64'(ack), 64'h4);
      check("single.busy", 64'(busy), 64'h1);
      req = '0;
      step("single_done");
      check("single_done.ack", 64'(ack), 64'h0);
      check("single_done.rf_en", 64'(rf_en), 64'h0);

      // 3. round robin from reset, each requester drops after its ack
      reset = 1'b1;
      step("rr_rst");
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, AW'(i), 32'hA0 + 32'(i));
      for (int k = 0; k < N; k++) begin
         step("rr_grant");
         check("rr.ack", 64'(ack), 64'(1 << k));
         check("rr.rf_en", 64'(rf_en), 64'(1 << k));
         check("rr.rf_d_in", 64'(rf_d_in), 64'(32'hA0 + 32'(k)));
         req[k] = 1'b0;
         step("rr_gap");
         check("rr_gap.busy", 64'(busy), 64'h0);
      end

      // 4. persistent request alternates ack with idle cycles
      set_req(1, 3'd6, 32'h12345678);
      for (int c = 1; c <= 6; c++) begin
         step("persist");
         check("persist.ack", 64'(ack), (c % 2 == 1) ? 64'h2 : 64'h0);
      end
      req = '0;
      step("persist_end");

      // 5. reset asserted during WRITE
      set_req(0, 3'd2, 32'hCAFEF00D);
      step("rw_grant");
      check("rw_grant.ack", 64'(ack), 64'h1);
      check("rw_grant.rf_en", 64'(rf_en), 64'h04);
      reset = 1'b1;
      step("rw_rst");
      check("rw_rst.ack", 64'(ack), 64'h0);
      check("rw_rst.last_grant", 64'(last_grant), 64'd3);
      step("rw_hold");
      check("rw_hold.busy", 64'(busy), 64'h0);
      reset = 1'b0;
      step("rw_regrant");
      check("rw_regrant.ack", 64'(ack), 64'h1);
      req = '0;
      step("rw_done");

      // 6. write to register 0
      set_req(3, 3'd0, 32'hFFFFFFFF);
      step("reg0");
      check("reg0.ack", 64'(ack), 64'h8);
      check("reg0.rf_en", 64'(rf_en), ZERO_REG ? 64'h0 : 64'h1);
      req = '0;
      step("reg0_done");

      // randomized traffic: requesters raise, hold, drop and re-request
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            r = $urandom;
            if (!req[i]) begin
               if (r[1:0] == 2'd0) set_req(i, AW'($urandom), $urandom);
            end else if (m_ack[i]) begin
               if (r[0]) req[i] = 1'b0;
               else begin
                  addr[i*AW +: AW]  = AW'($urandom);
                  wdata[i*DW +: DW] = $urandom;
               end
            end else if (r[4:2] == 3'd0) begin
               req[i] = 1'b0;
            end
         end
         reset = ($urandom_range(0, 49) == 0);
         step("rand");
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Round-robin write arbiter and sequencer in front of the 8 x 32-bit register file. Up to NUM_REQ requesters each present a write (register address + data) with a req/ack handshake. The block selects one requester, drives the register file's one-hot enable and shared data-in bus for exactly one cycle, and acknowledges the winner. It is the only writer of the register file's enable and data inputs.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DATA_W, 32, register data width
NUM_REG, 8, number of registers in the file
ADDR_W, 3, register address width; NUM_REG <= 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request, held until ack
addr  input  NUM_REQ*ADDR_W  packed register addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-cycle write-done pulse to the granted requester
rf_en  output  NUM_REG  one-hot register enable to the register file
rf_d_in  output  DATA_W  write data to the register file
busy  output  1  high while state is WRITE
last_grant  output  3  index of the most recently granted requester

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; ack = 0; rf_en = 0; rf_d_in = 0; busy = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered. No combinational path from input to output.
- FSM, 2 states:
  - IDLE: if any req bit is high, pick the winner by round-robin. Search starts at last_grant+1 (mod NUM_REQ) and takes the first set bit. On the edge, latch the winner's addr and wdata, then:
    - rf_en <= one-hot(addr); rf_d_in <= wdata; ack[winner] <= 1; last_grant <= winner; busy <= 1; go to WRITE.
    - If no req is high, stay in IDLE with all pulses 0.
  - WRITE: lasts exactly one cycle. The register file captures on the edge that ends this cycle, and the requester sees ack on the same edge. Next edge: rf_en, ack and busy <= 0; rf_d_in holds its last value; go to IDLE.
- The IDLE turnaround is mandatory, so a req still high on the cycle after ack is not double-counted. Peak throughput is 1 write per 2 cycles.
- Requester rules:
  - addr and wdata must be stable while req is high.
  - Dropping req before ack withdraws the request without error.
  - A req held high after ack is treated as a new request in the next IDLE.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,… Each requester waits at most NUM_REQ grants.
- Address out of range (addr >= NUM_REG): rf_en stays all 0, and the request is still acked and counted as a grant.
- rf_en is at most one-hot in every cycle. Exactly one ack bit is high when busy, and none when idle.
- Reset while in WRITE: the write and ack already driven in that cycle complete at that edge. The FSM then returns to reset values.
- Reset asserted in IDLE with req high: no grant is issued.
- Reset and req both high on the same edge: reset wins.

Optional Feature:
REG0_ZERO_EN
- Defined: register 0 is a hard-wired zero register. A write to address 0 still follows the full handshake (WRITE state, ack pulse, last_grant update), but rf_en[0] is never asserted.
- Undefined: address 0 is an ordinary writable register.

Test Plan:
1. Reset: hold reset 2 cycles with req=4'b1111 -> ack=0, rf_en=0, busy=0, last_grant=3; no grant while reset is high.
2. Single write: req[2]=1, addr2=5, wdata2=32'h01010101 -> one cycle later rf_en=8'b0010_0000, rf_d_in=32'h01010101, ack=4'b0100, busy=1. Next cycle all pulses 0.
3. Round-robin: all req high, addr_i=i, wdata_i=32'hA0+i, each requester drops req after its ack -> grant order 0,1,2,3 on cycles 1,3,5,7; rf_en takes the values 8'h01, 8'h02, 8'h04, 8'h08.
4. Persistent req: req[1] held high for 6 cycles, others 0 -> ack[1] pulses on cycles 1, 3 and 5, never on adjacent cycles.
5. Reset during WRITE: assert reset in the WRITE cycle -> that cycle's rf_en/ack complete; next cycle all 0, last_grant=3; a pending req is re-granted only after reset deasserts.
6. REG0_ZERO_EN: write addr=0, wdata=32'hFFFFFFFF -> defined: ack pulses, rf_en=0. Undefined: rf_en=8'h01.
